// File: rtl/regfile_dbg_port.sv
// Debug initiator for the integer register file: single read/write and a
// full dump over valid/ready channels, core signals pass through while idle.
module regfile_dbg_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_halted,
  output logic            o_busy,
  input  logic [AW-1:0]   i_core_rd,
  input  logic [XLEN-1:0] i_core_rd_d,
  input  logic            i_core_wr,
  input  logic [AW-1:0]   i_core_rs1,
  output logic [AW-1:0]   o_rf_rd,
  output logic [XLEN-1:0] o_rf_rd_d,
  output logic            o_rf_wr,
  output logic [AW-1:0]   o_rf_rs1,
  input  logic [XLEN-1:0] i_rf_rs1_d,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [AW-1:0]   o_rsp_addr,
  output logic [XLEN-1:0] o_rsp_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RESP,
    ST_DUMP_ADDR,
    ST_DUMP_WAIT,
    ST_DUMP_RESP
  } state_t;

  localparam logic [1:0]    OP_READ  = 2'b00;
  localparam logic [1:0]    OP_WRITE = 2'b01;
  localparam logic [1:0]    OP_DUMP  = 2'b10;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [AW-1:0]   r_cnt;
  logic            r_rsp_valid;
  logic [AW-1:0]   r_rsp_addr;
  logic [XLEN-1:0] r_rsp_data;

  logic w_idle;
  logic w_dump;
  logic w_req_fire;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_dump     = (r_state == ST_DUMP_ADDR) || (r_state == ST_DUMP_WAIT) ||
                      (r_state == ST_DUMP_RESP);
  // Reset is folded in so nothing is accepted while the block is held in reset.
  assign o_req_ready = w_idle && i_halted && !i_rst;
  assign w_req_fire  = i_req_valid && o_req_ready;
  assign o_busy      = !w_idle;

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_addr  = r_rsp_addr;
  assign o_rsp_data  = r_rsp_data;

  always_comb begin
    o_rf_rd   = r_addr;
    o_rf_rd_d = r_wdata;
    o_rf_wr   = 1'b0;
    o_rf_rs1  = w_dump ? r_cnt : r_addr;
    if (w_idle) begin
      o_rf_rd   = i_core_rd;
      o_rf_rd_d = i_core_rd_d;
      o_rf_wr   = i_core_wr && !i_rst;
      o_rf_rs1  = i_core_rs1;
    end else if (r_state == ST_WRITE) begin
      o_rf_wr = (r_addr != '0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            case (i_req_op)
              OP_READ:  r_state <= ST_RD_ADDR;
              OP_WRITE: r_state <= ST_WRITE;
              OP_DUMP: begin
                r_cnt   <= '0;
                r_state <= ST_DUMP_ADDR;
              end
              default: begin
                r_rsp_valid <= 1'b1;
                r_rsp_addr  <= i_req_addr;
                r_rsp_data  <= '0;
                r_state     <= ST_RESP;
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_addr  <= r_addr;
          r_rsp_data  <= (r_addr == '0) ? '0 : r_wdata;
          r_state     <= ST_RESP;
        end
        ST_RD_ADDR: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_addr  <= r_addr;
          r_rsp_data  <= i_rf_rs1_d;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_DUMP_ADDR: r_state <= ST_DUMP_WAIT;
        ST_DUMP_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_addr  <= r_cnt;
          r_rsp_data  <= i_rf_rs1_d;
          r_state     <= ST_DUMP_RESP;
        end
        ST_DUMP_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_cnt == LAST_IDX) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= ST_DUMP_ADDR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Directed bench for regfile_dbg_port with a registered-read regfile model.
module tb_regfile_dbg_port;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic            clk, rst, halted, busy;
  logic [AW-1:0]   core_rd, core_rs1, rf_rd, rf_rs1, req_addr, rsp_addr;
  logic [XLEN-1:0] core_rd_d, rf_rd_d, rf_rs1_d, req_wdata, rsp_data;
  logic            core_wr, rf_wr, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]      req_op;

  int total = 0;
  int bad = 0;

  logic [XLEN-1:0] mem [NREGS];
  logic            mem_clr;

  regfile_dbg_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_halted(halted), .o_busy(busy),
    .i_core_rd(core_rd), .i_core_rd_d(core_rd_d), .i_core_wr(core_wr), .i_core_rs1(core_rs1),
    .o_rf_rd(rf_rd), .o_rf_rd_d(rf_rd_d), .o_rf_wr(rf_wr), .o_rf_rs1(rf_rs1),
    .i_rf_rs1_d(rf_rs1_d),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_addr(rsp_addr), .o_rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: synchronous write, registered rs1 read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (rf_wr) begin
      mem[rf_rd] <= rf_rd_d;
    end
    rf_rs1_d <= mem[rf_rs1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1; halted = 1'b1;
    core_wr = 1'b1; core_rd = 5'd3; core_rd_d = 32'h77; core_rs1 = '0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #2;
    repeat (3) tick();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_addr !== 5'd0) begin bad++; $display("FAIL reset_rsp_addr got=%0d want=0", rsp_addr); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    total++; if (rf_wr !== 1'b0) begin bad++; $display("FAIL reset_rf_wr got=%b want=0", rf_wr); end
    core_wr = 1'b0; mem_clr = 1'b0; rst = 1'b0;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
    $display("reset released");
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] exp_d;
    logic            exp_wr;
    exp_d = (a == '0) ? '0 : d;
    exp_wr = (a != '0);
    req_valid = 1'b1; req_op = 2'b01; req_addr = a; req_wdata = d;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_req_ready got=%b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if (rf_wr !== exp_wr) begin bad++; $display("FAIL wr_rf_wr got=%b want=%b", rf_wr, exp_wr); end
    if (exp_wr) begin
      total++; if (rf_rd !== a || rf_rd_d !== d) begin bad++; $display("FAIL wr_rf_port got=%0d/%h want=%0d/%h", rf_rd, rf_rd_d, a, d); end
    end
    tick();
    total++; if (rf_wr !== 1'b0) begin bad++; $display("FAIL wr_rf_wr_once got=%b want=0", rf_wr); end
    total++; if (rsp_valid !== 1'b1 || rsp_addr !== a || rsp_data !== exp_d) begin
      bad++; $display("FAIL wr_rsp got=v%b/%0d/%h want=v1/%0d/%h", rsp_valid, rsp_addr, rsp_data, a, exp_d);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_done got=v%b/b%b want=v0/b0", rsp_valid, busy); end
    $display("write addr=%0d data=%h rsp=%h", a, d, exp_d);
  endtask

  task automatic test_read(input logic [AW-1:0] a, input logic [XLEN-1:0] exp_d);
    req_valid = 1'b1; req_op = 2'b00; req_addr = a;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rd_req_ready got=%b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid cycle=%0d got=%b want=0", c, rsp_valid); end
      tick();
    end
    total++; if (rsp_valid !== 1'b1 || rsp_addr !== a || rsp_data !== exp_d) begin
      bad++; $display("FAIL rd_rsp got=v%b/%0d/%h want=v1/%0d/%h", rsp_valid, rsp_addr, rsp_data, a, exp_d);
    end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin bad++; $display("FAIL rd_hold got=v%b/%h want=v1/%h", rsp_valid, rsp_data, exp_d); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_done got=v%b/b%b want=v0/b0", rsp_valid, busy); end
    $display("read addr=%0d data=%h", a, exp_d);
  endtask

  task automatic test_reserved();
    req_valid = 1'b1; req_op = 2'b11; req_addr = 5'd9; req_wdata = 32'hFFFF_FFFF;
    tick();
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_addr !== 5'd9 || rsp_data !== 32'h0) begin
      bad++; $display("FAIL rsv_rsp got=v%b/%0d/%h want=v1/9/0", rsp_valid, rsp_addr, rsp_data);
    end
    total++; if (rf_wr !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rsv_state got=wr%b/b%b want=wr0/b1", rf_wr, busy); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rsv_done got=%b want=0", busy); end
    $display("reserved addr=9 data=0");
  endtask

  task automatic test_passthrough();
    halted = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 5'd1;
    core_wr = 1'b1; core_rd = 5'd7; core_rd_d = 32'h55; core_rs1 = 5'd3;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL pt_req_ready got=%b want=0", req_ready); end
    total++; if (rf_wr !== 1'b1 || rf_rd !== 5'd7 || rf_rd_d !== 32'h55 || rf_rs1 !== 5'd3) begin
      bad++; $display("FAIL pt_mux got=%b/%0d/%h/%0d want=1/7/55/3", rf_wr, rf_rd, rf_rd_d, rf_rs1);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL pt_no_rsp got=v%b/b%b want=v0/b0", rsp_valid, busy); end
    end
    req_valid = 1'b0; core_wr = 1'b0; halted = 1'b1;
    tick();
    $display("passthrough core_rd=7 data=55");
  endtask

  task automatic preload();
    for (int i = 0; i < NREGS; i++) begin
      core_wr = 1'b1; core_rd = AW'(i); core_rd_d = 32'h100 + i;
      tick();
    end
    core_wr = 1'b0;
  endtask

  task automatic test_dump();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0;
    int k = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [XLEN-1:0] pd = '0;
    req_valid = 1'b1; req_op = 2'b10; req_addr = 5'd17;
    tick();
    req_valid = 1'b0;
    while (n < NREGS && cyc < 2000) begin
      rsp_ready = pat[k % 4];
      k++;
      if (prev_stall) begin
        total++; if (rsp_valid !== 1'b1 || rsp_addr !== pa || rsp_data !== pd) begin
          bad++; $display("FAIL dump_hold got=v%b/%0d/%h want=v1/%0d/%h", rsp_valid, rsp_addr, rsp_data, pa, pd);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        total++; if (rsp_addr !== n[AW-1:0] || rsp_data !== XLEN'(32'h100 + n)) begin
          bad++; $display("FAIL dump_rsp got=%0d/%h want=%0d/%h", rsp_addr, rsp_data, n, 32'h100 + n);
        end
        $display("dump addr=%0d data=%h", rsp_addr, rsp_data);
        n++;
      end
      prev_stall = (rsp_valid === 1'b1) && !rsp_ready;
      pa = rsp_addr; pd = rsp_data;
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    total++; if (n != NREGS) begin bad++; $display("FAIL dump_count got=%0d want=%0d", n, NREGS); end
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL dump_end got=b%b/v%b want=b0/v0", busy, rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      rsp_ready = 1'b1;
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL dump_extra got=%b want=0", rsp_valid); end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    bit found = 1'b0;
    int n = 0;
    int cyc = 0;
    req_valid = 1'b1; req_op = 2'b10;
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 500 && !found; c++) begin
      if (rsp_valid === 1'b1 && rsp_addr === 5'd9) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rstdump_timeout got=none want=addr9"); end
    tick();
    tick();
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rstdump_pre got=b%b/v%b want=b1/v0", busy, rsp_valid); end
    rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rf_wr !== 1'b0) begin
      bad++; $display("FAIL rstdump_abort got=v%b/b%b/w%b want=0/0/0", rsp_valid, busy, rf_wr);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("reset during dump at cnt=10");
    req_valid = 1'b1; req_op = 2'b10;
    tick();
    req_valid = 1'b0;
    while (busy === 1'b1 && cyc < 500) begin
      if (rsp_valid === 1'b1) begin
        if (n == 0) begin
          total++; if (rsp_addr !== 5'd0 || rsp_data !== 32'h100) begin
            bad++; $display("FAIL rstdump_restart got=%0d/%h want=0/00000100", rsp_addr, rsp_data);
          end
        end
        n++;
      end
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    total++; if (n != NREGS) begin bad++; $display("FAIL rstdump_count got=%0d want=%0d", n, NREGS); end
    $display("redump responses=%0d", n);
  endtask

  task automatic test_halt_drop();
    bit got = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 5'd12;
    tick();
    req_valid = 1'b0;
    tick();
    halted = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hd_req_ready got=%b want=0", req_ready); end
      if (rsp_valid === 1'b1) got = 1'b1;
      else tick();
    end
    total++; if (!got || rsp_addr !== 5'd12 || rsp_data !== 32'h10C) begin
      bad++; $display("FAIL hd_rsp got=v%b/%0d/%h want=v1/12/0000010c", got, rsp_addr, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (busy !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL hd_idle got=b%b/r%b want=b0/r0", busy, req_ready); end
    halted = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hd_rehalt got=%b want=1", req_ready); end
    $display("read with halt drop addr=12 data=%h", rsp_data);
  endtask

  initial begin
    test_reset();
    test_write(5'd5, 32'hDEADBEEF);
    test_read(5'd5, 32'hDEADBEEF);
    test_write(5'd0, 32'h1234);
    test_read(5'd0, 32'h0);
    test_reserved();
    test_passthrough();
    preload();
    test_dump();
    test_reset_mid_dump();
    test_halt_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
